// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer in front of a
// single-port data memory with combinational read data.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   p0_* / p1_*       requester ports (port 0 = CPU LSU, port 1 = DMA/debug):
//                     req/lock/we/addr/wdata in; gnt (combinational),
//                     rvalid/rdata/err (registered, one cycle after gnt) out
//   mem_we/addr/wdata to the memory
//   mem_rdata         from the memory (combinational read of mem_addr)
//
// A port may take burst ownership by granting with lock=1. A locked burst
// ends on an unlocked beat, after MAX_BURST beats, or after the owner has
// been idle for two consecutive cycles.
module dmem_arbiter #(
    parameter logic [31:0] ADDR_MAX  = 32'h8000,
    parameter int          MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_req,
    input  logic        p0_lock,
    input  logic        p0_we,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_rvalid,
    output logic [31:0] p0_rdata,
    output logic        p0_err,
    input  logic        p1_req,
    input  logic        p1_lock,
    input  logic        p1_we,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_rvalid,
    output logic [31:0] p1_rdata,
    output logic        p1_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    localparam logic [8:0] MAX_B   = 9'(MAX_BURST);
    // A one-beat cap would release on the very beat that takes the lock,
    // so locking is meaningless and never entered.
    localparam bit         LOCK_EN = (MAX_BURST > 1);

    state_t     state, state_nxt;
    logic       last_gnt, last_gnt_nxt;
    logic [7:0] burst_cnt, burst_cnt_nxt;
    logic       idle_cnt, idle_cnt_nxt;

    logic sel_valid;   // some port wins this cycle
    logic sel;         // index of the winning port
    logic sel_we, sel_lock, in_range;

    // Winner selection.
    always_comb begin
        sel_valid = 1'b0;
        sel       = 1'b0;
        case (state)
            LOCK0: begin
                sel       = 1'b0;
                sel_valid = p0_req;
            end
            LOCK1: begin
                sel       = 1'b1;
                sel_valid = p1_req;
            end
            default: begin
                if (p0_req && p1_req) begin
                    sel_valid = 1'b1;
                    sel       = ~last_gnt;
                end else if (p0_req) begin
                    sel_valid = 1'b1;
                    sel       = 1'b0;
                end else if (p1_req) begin
                    sel_valid = 1'b1;
                    sel       = 1'b1;
                end
            end
        endcase
    end

    assign p0_gnt    = sel_valid & ~sel;
    assign p1_gnt    = sel_valid & sel;
    // Port 0 drives the memory bus whenever port 1 is not the winner.
    assign mem_addr  = p1_gnt ? p1_addr  : p0_addr;
    assign mem_wdata = p1_gnt ? p1_wdata : p0_wdata;
    assign sel_we    = sel ? p1_we   : p0_we;
    assign sel_lock  = sel ? p1_lock : p0_lock;
    assign in_range  = (mem_addr <= ADDR_MAX);
    assign mem_we    = sel_valid & sel_we & in_range & ~rst;

    // Lock sequencing and round-robin history.
    always_comb begin
        state_nxt     = state;
        burst_cnt_nxt = burst_cnt;
        idle_cnt_nxt  = idle_cnt;
        last_gnt_nxt  = sel_valid ? sel : last_gnt;
        case (state)
            IDLE: begin
                if (sel_valid && sel_lock && LOCK_EN) begin
                    state_nxt     = sel ? LOCK1 : LOCK0;
                    burst_cnt_nxt = 8'd1;
                    idle_cnt_nxt  = 1'b0;
                end
            end
            default: begin
                if (sel_valid) begin
                    idle_cnt_nxt = 1'b0;
                    if (!sel_lock || (({1'b0, burst_cnt} + 9'd1) >= MAX_B)) begin
                        state_nxt     = IDLE;
                        burst_cnt_nxt = 8'd0;
                    end else begin
                        burst_cnt_nxt = burst_cnt + 8'd1;
                    end
                end else if (idle_cnt) begin
                    state_nxt     = IDLE;
                    burst_cnt_nxt = 8'd0;
                    idle_cnt_nxt  = 1'b0;
                end else begin
                    idle_cnt_nxt = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            burst_cnt <= 8'd0;
            idle_cnt  <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_gnt  <= last_gnt_nxt;
            burst_cnt <= burst_cnt_nxt;
            idle_cnt  <= idle_cnt_nxt;
        end
    end

    // Response registers: memory read data never reaches a requester
    // combinationally; out-of-range reads return zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p0_rvalid <= 1'b0;
            p0_err    <= 1'b0;
            p0_rdata  <= 32'd0;
            p1_rvalid <= 1'b0;
            p1_err    <= 1'b0;
            p1_rdata  <= 32'd0;
        end else begin
            p0_rvalid <= p0_gnt & ~p0_we;
            p0_err    <= p0_gnt & ~in_range;
            p1_rvalid <= p1_gnt & ~p1_we;
            p1_err    <= p1_gnt & ~in_range;
            if (p0_gnt && !p0_we) p0_rdata <= in_range ? mem_rdata : 32'd0;
            if (p1_gnt && !p1_we) p1_rdata <= in_range ? mem_rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural
// single-port memory (combinational read, write on rising edge).
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        p0_req, p0_lock, p0_we;
    logic [31:0] p0_addr, p0_wdata;
    logic        p0_gnt, p0_rvalid, p0_err;
    logic [31:0] p0_rdata;
    logic        p1_req, p1_lock, p1_we;
    logic [31:0] p1_addr, p1_wdata;
    logic        p1_gnt, p1_rvalid, p1_err;
    logic [31:0] p1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_lock(p0_lock), .p0_we(p0_we), .p0_addr(p0_addr),
        .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
        .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_lock(p1_lock), .p1_we(p1_we), .p1_addr(p1_addr),
        .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
        .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    logic [31:0] mem [0:65535];
    assign mem_rdata = (mem_addr <= 32'h8000) ? mem[mem_addr[15:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) if (mem_we) mem[mem_addr[15:0]] <= mem_wdata;

    function automatic logic [31:0] pat(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    typedef struct packed {
        logic        port;
        logic [31:0] data;
        logic        err;
    } exp_t;
    exp_t sb[$];
    exp_t e;

    int n_cmp = 0;
    int n_bad = 0;

    // Sampled values: gnt/mem_we just after inputs settle, responses #1 after the edge.
    logic        g0, g1, mwe;
    logic        rv0, rv1, er0, er1;
    logic [31:0] rd0, rd1;

    task automatic cyc();
        #1;
        g0 = p0_gnt; g1 = p1_gnt; mwe = mem_we;
        @(posedge clk);
        #1;
        rv0 = p0_rvalid; rv1 = p1_rvalid; er0 = p0_err; er1 = p1_err;
        rd0 = p0_rdata; rd1 = p1_rdata;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        p0_req = 0; p0_lock = 0; p0_we = 0; p0_addr = 0; p0_wdata = 0;
        p1_req = 0; p1_lock = 0; p1_we = 0; p1_addr = 0; p1_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        n_cmp++; if (p0_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rv0 got %b want 0", p0_rvalid); end
        n_cmp++; if (p1_rvalid !== 1'b0) begin n_bad++; $display("FAIL rst_rv1 got %b want 0", p1_rvalid); end
        n_cmp++; if ({p0_err, p1_err} !== 2'b00) begin n_bad++; $display("FAIL rst_err got %b want 00", {p0_err, p1_err}); end
        n_cmp++; if (p0_rdata !== 32'd0 || p1_rdata !== 32'd0) begin n_bad++; $display("FAIL rst_rdata got %h/%h want 0/0", p0_rdata, p1_rdata); end
        n_cmp++; if ({p0_gnt, p1_gnt, mem_we} !== 3'b000) begin n_bad++; $display("FAIL rst_idle got %b want 000", {p0_gnt, p1_gnt, mem_we}); end
        // mem_we must be suppressed while reset is asserted even with a write pending
        @(negedge clk);
        rst = 1; p0_req = 1; p0_we = 1; p0_addr = 32'h10; p0_wdata = 32'h1;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst = 0;
    endtask

    task automatic test_write_read();
        do_reset();
        p0_req = 1; p0_we = 1; p0_addr = 32'h2000; p0_wdata = 32'hDEAD_BEEF;
        cyc();
        n_cmp++; if (g0 !== 1'b1) begin n_bad++; $display("FAIL wr_gnt got %b want 1", g0); end
        n_cmp++; if (mwe !== 1'b1) begin n_bad++; $display("FAIL wr_mem_we got %b want 1", mwe); end
        n_cmp++; if ({rv0, er0} !== 2'b00) begin n_bad++; $display("FAIL wr_rv_err got %b want 00", {rv0, er0}); end
        p0_we = 0; p0_wdata = 0;
        sb.push_back('{port: 1'b0, data: 32'hDEAD_BEEF, err: 1'b0});
        cyc();
        n_cmp++; if (g0 !== 1'b1 || mwe !== 1'b0) begin n_bad++; $display("FAIL rd_gnt got gnt=%b we=%b want 1/0", g0, mwe); end
        e = sb.pop_front();
        n_cmp++; if (rv0 !== 1'b1 || rd0 !== e.data || er0 !== e.err) begin n_bad++; $display("FAIL rd_data got rv=%b %h err=%b want 1 %h %b", rv0, rd0, er0, e.data, e.err); end
        idle_inputs();
        cyc();
        n_cmp++; if (rv0 !== 1'b0 || rd0 !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL rd_hold got rv=%b %h want 0 deadbeef", rv0, rd0); end
    endtask

    task automatic test_round_robin();
        int w;
        do_reset();
        p0_req = 1; p0_addr = 32'h100;
        p1_req = 1; p1_addr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            w = i % 2;
            sb.push_back('{port: w[0], data: (w == 0) ? pat(32'h100) : pat(32'h200), err: 1'b0});
            cyc();
            n_cmp++; if (g0 !== (w == 0) || g1 !== (w == 1)) begin n_bad++; $display("FAIL rr_gnt[%0d] got %b%b want port %0d", i, g0, g1, w); end
            e = sb.pop_front();
            n_cmp++; if (rv0 !== (w == 0) || rv1 !== (w == 1)) begin n_bad++; $display("FAIL rr_rvalid[%0d] got %b%b want port %0d", i, rv0, rv1, w); end
            n_cmp++; if (((e.port ? rd1 : rd0) !== e.data)) begin n_bad++; $display("FAIL rr_rdata[%0d] got %h want %h", i, e.port ? rd1 : rd0, e.data); end
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_burst_cap();
        // 0 = port 0, 1 = port 1, 2 = nobody
        int exp_w[16] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 1, 2, 2, 0};
        int beat;
        beat = 0;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            p0_req = (c > 0); p0_addr = 32'h400; p0_we = 0; p0_lock = 0;
            p1_req = (beat < 12); p1_lock = 1; p1_we = 0; p1_addr = 32'h300 + beat;
            if (exp_w[c] == 0) sb.push_back('{port: 1'b0, data: pat(32'h400), err: 1'b0});
            if (exp_w[c] == 1) sb.push_back('{port: 1'b1, data: pat(32'h300 + beat), err: 1'b0});
            cyc();
            n_cmp++; if (g0 !== (exp_w[c] == 0) || g1 !== (exp_w[c] == 1)) begin n_bad++; $display("FAIL burst_gnt[%0d] got %b%b want %0d", c, g0, g1, exp_w[c]); end
            n_cmp++; if (rv0 !== (exp_w[c] == 0) || rv1 !== (exp_w[c] == 1)) begin n_bad++; $display("FAIL burst_rvalid[%0d] got %b%b want %0d", c, rv0, rv1, exp_w[c]); end
            if (exp_w[c] != 2) begin
                e = sb.pop_front();
                n_cmp++; if ((e.port ? rd1 : rd0) !== e.data) begin n_bad++; $display("FAIL burst_rdata[%0d] got %h want %h", c, e.port ? rd1 : rd0, e.data); end
            end
            if (exp_w[c] == 1) beat++;
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_out_of_range();
        do_reset();
        p0_req = 1; p0_we = 1; p0_addr = 32'h8001; p0_wdata = 32'h1234_5678;
        cyc();
        n_cmp++; if (g0 !== 1'b1 || mwe !== 1'b0) begin n_bad++; $display("FAIL oor_wr got gnt=%b we=%b want 1/0", g0, mwe); end
        n_cmp++; if (er0 !== 1'b1 || rv0 !== 1'b0) begin n_bad++; $display("FAIL oor_wr_err got err=%b rv=%b want 1/0", er0, rv0); end
        idle_inputs();
        cyc();
        n_cmp++; if (er0 !== 1'b0) begin n_bad++; $display("FAIL oor_err_pulse got %b want 0", er0); end
        p0_req = 1; p0_addr = 32'h8001;
        sb.push_back('{port: 1'b0, data: 32'd0, err: 1'b1});
        cyc();
        e = sb.pop_front();
        n_cmp++; if (rv0 !== 1'b1 || rd0 !== e.data || er0 !== e.err) begin n_bad++; $display("FAIL oor_rd got rv=%b %h err=%b want 1 %h %b", rv0, rd0, er0, e.data, e.err); end
        p0_addr = 32'h8000;
        sb.push_back('{port: 1'b0, data: pat(32'h8000), err: 1'b0});
        cyc();
        e = sb.pop_front();
        n_cmp++; if (rv0 !== 1'b1 || rd0 !== e.data || er0 !== e.err) begin n_bad++; $display("FAIL edge_rd got rv=%b %h err=%b want 1 %h %b", rv0, rd0, er0, e.data, e.err); end
        p0_we = 1; p0_wdata = 32'hA5A5_A5A5;
        cyc();
        n_cmp++; if (mwe !== 1'b1 || er0 !== 1'b0) begin n_bad++; $display("FAIL edge_wr got we=%b err=%b want 1/0", mwe, er0); end
        idle_inputs();
        cyc();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        p0_req = 1; p0_lock = 1; p0_we = 1; p0_addr = 32'h500; p0_wdata = 32'h11;
        cyc();
        n_cmp++; if (g0 !== 1'b1 || mwe !== 1'b1) begin n_bad++; $display("FAIL mb_beat0 got gnt=%b we=%b want 1/1", g0, mwe); end
        p0_addr = 32'h8005; p1_req = 1; p1_addr = 32'h600;
        cyc();
        n_cmp++; if (g0 !== 1'b1 || g1 !== 1'b0) begin n_bad++; $display("FAIL mb_lock got %b%b want 10", g0, g1); end
        n_cmp++; if (er0 !== 1'b1) begin n_bad++; $display("FAIL mb_err got %b want 1", er0); end
        p0_addr = 32'h502;
        #1;
        n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL mb_we_active got %b want 1", mem_we); end
        rst = 1;
        #1;
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL mb_we_drop got %b want 0", mem_we); end
        n_cmp++; if ({p0_rvalid, p1_rvalid, p0_err, p1_err} !== 4'b0000) begin n_bad++; $display("FAIL mb_flags got %b want 0000", {p0_rvalid, p1_rvalid, p0_err, p1_err}); end
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        p0_lock = 0; p0_we = 0; p0_addr = 32'h700;
        sb.push_back('{port: 1'b0, data: pat(32'h700), err: 1'b0});
        cyc();
        n_cmp++; if (g0 !== 1'b1 || g1 !== 1'b0) begin n_bad++; $display("FAIL mb_tie got %b%b want 10", g0, g1); end
        e = sb.pop_front();
        n_cmp++; if (rv0 !== 1'b1 || rd0 !== e.data) begin n_bad++; $display("FAIL mb_rd got rv=%b %h want 1 %h", rv0, rd0, e.data); end
        p0_req = 0;
        sb.push_back('{port: 1'b1, data: pat(32'h600), err: 1'b0});
        cyc();
        n_cmp++; if (g1 !== 1'b1) begin n_bad++; $display("FAIL mb_p1 got %b want 1", g1); end
        e = sb.pop_front();
        n_cmp++; if (rv1 !== 1'b1 || rd1 !== e.data) begin n_bad++; $display("FAIL mb_p1_rd got rv=%b %h want 1 %h", rv1, rd1, e.data); end
        idle_inputs();
        cyc();
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = pat(i);
        idle_inputs();
        rst = 1;
        @(negedge clk);
        test_reset();
        test_write_read();
        test_round_robin();
        test_burst_cap();
        test_out_of_range();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
